// File: rtl/int_pin_rcvr.sv
// ============================================================================
// int_pin_rcvr
// ----------------------------------------------------------------------------
// Host-side receiver for the INT pin driven by the interrupt controller,
// clocked by the 32 kHz clock.
//   * Two-flop synchroniser on the pin, then polarity normalisation.
//   * Glitch rejection: an assertion is accepted only after
//     N = max(rg_min_width,1) consecutive active samples.
//   * Accepted assertions raise a sticky int_req, bump int_cnt and, when the
//     pin drops, report the active-sample width on last_width/width_vld.
//   * Host acknowledge returns a one-cycle clr_pulse toward the controller.
//   * Level mode: flags stuck_err if the pin stays active rg_clr_to cycles
//     after clr_pulse.
//
// Optional feature macro: INT_RX_TIMESTAMP_EN
//   defined   : free-running TW-bit cycle counter, latched into last_ts on
//               every acceptance.
//   undefined : no counter, last_ts tied to 0.
//
// Ports
//   clk_32k          in   32 kHz clock, rising edge
//   rst              in   asynchronous reset, active-high
//   int_in           in   INT pin, asynchronous
//   rg_int_low_en    in   0: pin active high, 1: pin active low
//   rg_int_level_en  in   0: pulse mode, 1: level mode
//   rg_min_width     in   qualify threshold (0 behaves as 1)
//   rg_clr_to        in   level-mode clear timeout in cycles (0 disables)
//   int_ack          in   host acknowledge, 1-cycle pulse
//   err_clr          in   clears stuck_err
//   int_req          out  pending interrupt to host (sticky)
//   clr_pulse        out  1-cycle clear toward the controller
//   last_width       out  active-sample count of last accepted assertion
//   width_vld        out  1-cycle strobe when last_width updates
//   int_cnt          out  accepted assertions, saturating
//   glitch_cnt       out  rejected assertions, saturating
//   stuck_err        out  sticky stuck-level error
//   last_ts          out  timestamp of last accepted assertion
//   dbg_state        out  FSM state (0 IDLE, 1 QUAL, 2 ASSERTED)
//
// Handshake: int_ack is a single-cycle request; it is taken on the edge where
// int_req is high or an assertion is being accepted, and answered by
// clr_pulse high for exactly the following cycle. Untaken acks are dropped.
// ============================================================================
module int_pin_rcvr #(
   parameter int WW = 11,
   parameter int CW = 8,
   parameter int TW = 16
) (
   input  logic          clk_32k,
   input  logic          rst,
   input  logic          int_in,
   input  logic          rg_int_low_en,
   input  logic          rg_int_level_en,
   input  logic [WW-1:0] rg_min_width,
   input  logic [7:0]    rg_clr_to,
   input  logic          int_ack,
   input  logic          err_clr,
   output logic          int_req,
   output logic          clr_pulse,
   output logic [WW-1:0] last_width,
   output logic          width_vld,
   output logic [CW-1:0] int_cnt,
   output logic [CW-1:0] glitch_cnt,
   output logic          stuck_err,
   output logic [TW-1:0] last_ts,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_QUAL     = 2'd1,
      ST_ASSERTED = 2'd2
   } state_e;

   localparam logic [WW-1:0] WMAX = {WW{1'b1}};
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   state_e        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic          act;
   logic [WW-1:0] n_thr;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [WW:0]   wcnt_inc;
   logic          glitch, width_end, enter_asrt, ack_take;
   logic          pending_q, pending_d;
   logic          clr_pulse_q, clr_pulse_d;
   logic [WW-1:0] last_width_q, last_width_d;
   logic          width_vld_q, width_vld_d;
   logic [CW-1:0] int_cnt_q, int_cnt_d;
   logic [CW-1:0] glitch_cnt_q, glitch_cnt_d;
   logic          chk_en, stuck_set;
   logic [7:0]    tcnt_q, tcnt_d;
   logic          arm_q, arm_d;
   logic          stuck_q, stuck_d;

   // Normalised pin level; polarity register applies combinationally so a
   // change of rg_int_low_en can start or end an assertion by itself.
   assign act      = sync2_q ^ rg_int_low_en;
   assign n_thr    = (rg_min_width == '0) ? WW'(1) : rg_min_width;
   assign wcnt_inc = {1'b0, wcnt_q} + (WW + 1)'(1);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_32k or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (act) state_d = (n_thr == WW'(1)) ? ST_ASSERTED : ST_QUAL;
         end
         ST_QUAL: begin
            // >= rather than == so a threshold lowered mid-qualification
            // still accepts instead of waiting for a count it already passed.
            if (!act)                              state_d = ST_IDLE;
            else if (wcnt_inc >= {1'b0, n_thr})    state_d = ST_ASSERTED;
         end
         ST_ASSERTED: begin
            if (!act) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wcnt_d    = wcnt_q;
      glitch    = 1'b0;
      width_end = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (act) wcnt_d = WW'(1);
         end
         ST_QUAL: begin
            if (act) wcnt_d = wcnt_inc[WW-1:0];
            else     glitch = 1'b1;
         end
         ST_ASSERTED: begin
            if (act) begin
               if (wcnt_q != WMAX) wcnt_d = wcnt_inc[WW-1:0];
            end else begin
               width_end = 1'b1;
            end
         end
         default: wcnt_d = '0;
      endcase
   end

   assign dbg_state  = state_q;
   assign enter_asrt = (state_q != ST_ASSERTED) && (state_d == ST_ASSERTED);

   // -------------------------------------------------- pending / ack path
   // An ack coinciding with acceptance is still answered, but the new
   // acceptance keeps int_req set.
   assign ack_take    = int_ack && (pending_q || enter_asrt);
   assign pending_d   = enter_asrt ? 1'b1 : (ack_take ? 1'b0 : pending_q);
   assign clr_pulse_d = ack_take;

   assign last_width_d = width_end ? wcnt_q : last_width_q;
   assign width_vld_d  = width_end;
   assign int_cnt_d    = (enter_asrt && int_cnt_q != CMAX) ? int_cnt_q + CW'(1) : int_cnt_q;
   assign glitch_cnt_d = (glitch && glitch_cnt_q != CMAX) ? glitch_cnt_q + CW'(1) : glitch_cnt_q;

   // ------------------------------------------------------- stuck check
   // tcnt counts active samples starting with the clr_pulse cycle; it
   // saturates, and stuck is raised only on the increment that lands on
   // rg_clr_to, so err_clr can clear the flag while the pin is still held.
   assign chk_en = rg_int_level_en && (rg_clr_to != 8'd0);

   always_comb begin
      tcnt_d    = tcnt_q;
      arm_d     = arm_q;
      stuck_set = 1'b0;
      if (!chk_en || !act) begin
         tcnt_d = 8'd0;
         arm_d  = 1'b0;
      end else if (clr_pulse_q) begin
         tcnt_d    = 8'd1;
         arm_d     = 1'b1;
         stuck_set = (rg_clr_to == 8'd1);
      end else if (arm_q && tcnt_q != 8'hFF) begin
         tcnt_d    = tcnt_q + 8'd1;
         stuck_set = (tcnt_d == rg_clr_to);
      end
   end

   assign stuck_d = stuck_set ? 1'b1 : (err_clr ? 1'b0 : stuck_q);

   // -------------------------------------------------------- registers
   always_ff @(posedge clk_32k or posedge rst) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         wcnt_q       <= '0;
         pending_q    <= 1'b0;
         clr_pulse_q  <= 1'b0;
         last_width_q <= '0;
         width_vld_q  <= 1'b0;
         int_cnt_q    <= '0;
         glitch_cnt_q <= '0;
         tcnt_q       <= 8'd0;
         arm_q        <= 1'b0;
         stuck_q      <= 1'b0;
      end else begin
         sync1_q      <= int_in;
         sync2_q      <= sync1_q;
         wcnt_q       <= wcnt_d;
         pending_q    <= pending_d;
         clr_pulse_q  <= clr_pulse_d;
         last_width_q <= last_width_d;
         width_vld_q  <= width_vld_d;
         int_cnt_q    <= int_cnt_d;
         glitch_cnt_q <= glitch_cnt_d;
         tcnt_q       <= tcnt_d;
         arm_q        <= arm_d;
         stuck_q      <= stuck_d;
      end
   end

   assign int_req    = pending_q;
   assign clr_pulse  = clr_pulse_q;
   assign last_width = last_width_q;
   assign width_vld  = width_vld_q;
   assign int_cnt    = int_cnt_q;
   assign glitch_cnt = glitch_cnt_q;
   assign stuck_err  = stuck_q;

`ifdef INT_RX_TIMESTAMP_EN
   logic [TW-1:0] ts_q, ts_d;
   logic [TW-1:0] last_ts_q, last_ts_d;

   assign ts_d      = ts_q + TW'(1);
   assign last_ts_d = enter_asrt ? ts_q : last_ts_q;

   always_ff @(posedge clk_32k or posedge rst) begin
      if (rst) begin
         ts_q      <= '0;
         last_ts_q <= '0;
      end else begin
         ts_q      <= ts_d;
         last_ts_q <= last_ts_d;
      end
   end

   assign last_ts = last_ts_q;
`else
   assign last_ts = '0;
`endif

endmodule

// File: tb/tb_int_pin_rcvr.sv
`timescale 1ns/1ps
module tb_int_pin_rcvr;
   localparam int WW   = 11;
   localparam int CW   = 8;
   localparam int TW   = 16;
   localparam int WMAX = (1 << WW) - 1;
   localparam int CMAX = (1 << CW) - 1;

   // ---------------------------------------------------- clock / reset
   logic          clk_32k = 1'b0;
   logic          rst = 1'b1;
   logic          int_in = 1'b0;
   logic          rg_int_low_en = 1'b0;
   logic          rg_int_level_en = 1'b0;
   logic [WW-1:0] rg_min_width = '0;
   logic [7:0]    rg_clr_to = '0;
   logic          int_ack = 1'b0;
   logic          err_clr = 1'b0;
   logic          int_req, clr_pulse, width_vld, stuck_err;
   logic [WW-1:0] last_width;
   logic [CW-1:0] int_cnt, glitch_cnt;
   logic [TW-1:0] last_ts;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_32k = ~clk_32k;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   int_pin_rcvr #(.WW(WW), .CW(CW), .TW(TW)) dut (
      .clk_32k         (clk_32k),
      .rst             (rst),
      .int_in          (int_in),
      .rg_int_low_en   (rg_int_low_en),
      .rg_int_level_en (rg_int_level_en),
      .rg_min_width    (rg_min_width),
      .rg_clr_to       (rg_clr_to),
      .int_ack         (int_ack),
      .err_clr         (err_clr),
      .int_req         (int_req),
      .clr_pulse       (clr_pulse),
      .last_width      (last_width),
      .width_vld       (width_vld),
      .int_cnt         (int_cnt),
      .glitch_cnt      (glitch_cnt),
      .stuck_err       (stuck_err),
      .last_ts         (last_ts),
      .dbg_state       (dbg_state)
   );

   // ------------------------------------------------- reference model
   // Behavioural view: the pin is seen two edges late; an assertion is a run
   // of consecutive active samples, accepted once the run reaches N, and its
   // width is the run length when it ends. Expected widths are queued for
   // the scoreboard.
   logic          m_s1, m_s2, m_in, m_req, m_clr, m_wv, m_stk, m_arm;
   int            m_run, m_tcnt, m_ic, m_gc, m_lw, m_ts, m_lts;
   logic [WW-1:0] exp_q[$];

   always @(posedge clk_32k or posedge rst) begin : p_model
      bit act, entry, take, chk, hit, wend;
      int n, run_n, tcnt_n;
      if (rst) begin
         m_s1 <= 0; m_s2 <= 0; m_in <= 0; m_req <= 0; m_clr <= 0; m_wv <= 0;
         m_stk <= 0; m_arm <= 0; m_run <= 0; m_tcnt <= 0; m_ic <= 0; m_gc <= 0;
         m_lw <= 0; m_ts <= 0; m_lts <= 0;
         exp_q.delete();
      end else begin
         act   = m_s2 ^ rg_int_low_en;
         n     = (rg_min_width == '0) ? 1 : int'(rg_min_width);
         run_n = act ? m_run + 1 : 0;
         entry = act && !m_in && (run_n >= n);
         wend  = !act && m_in;
         take  = int_ack && (m_req || entry);
         chk   = rg_int_level_en && (rg_clr_to != 8'd0);
         hit   = 0;
         tcnt_n = 0;
         if (chk && act && (m_clr || m_arm)) begin
            tcnt_n = m_clr ? 1 : m_tcnt + 1;
            hit    = (tcnt_n == int'(rg_clr_to));
         end
         m_s1   <= int_in;
         m_s2   <= m_s1;
         m_run  <= run_n;
         m_in   <= act && (m_in || entry);
         m_req  <= entry ? 1'b1 : (take ? 1'b0 : m_req);
         m_clr  <= take;
         m_wv   <= wend;
         if (wend) begin
            m_lw <= (m_run > WMAX) ? WMAX : m_run;
            exp_q.push_back(WW'((m_run > WMAX) ? WMAX : m_run));
         end
         if (entry && m_ic < CMAX) m_ic <= m_ic + 1;
         if (!act && !m_in && m_run > 0 && m_gc < CMAX) m_gc <= m_gc + 1;
         m_tcnt <= tcnt_n;
         m_arm  <= chk && act && (m_clr || m_arm);
         m_stk  <= hit ? 1'b1 : (err_clr ? 1'b0 : m_stk);
         m_ts   <= (m_ts + 1) % (1 << TW);
`ifdef INT_RX_TIMESTAMP_EN
         if (entry) m_lts <= m_ts;
`endif
      end
   end

   // ---------------------------------------------------- driver tasks
   task automatic do_reset();
      @(negedge clk_32k);
      rst = 1'b1; int_in = 1'b0; int_ack = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk_32k);
      rst = 1'b0;
   endtask

   task automatic set_cfg(input logic low, input logic lvl, input int mw, input int cto);
      rg_int_low_en   = low;
      rg_int_level_en = lvl;
      rg_min_width    = WW'(mw);
      rg_clr_to       = 8'(cto);
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      logic [48:0] outs;
      set_cfg(0, 0, 0, 0);
      @(negedge clk_32k);
      int_in = 1'b1; rst = 1'b1;
      repeat (3) @(negedge clk_32k);
      outs = {int_req, clr_pulse, width_vld, stuck_err, last_width, int_cnt, glitch_cnt, last_ts, dbg_state};
      n_checks++;
      if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
      rst = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         @(negedge clk_32k);
         n_checks++;
         if (int_req !== (e == 3)) begin
            n_fail++; $display("FAIL reset_accept_edge%0d: int_req=%b expected %b", e, int_req, e == 3);
         end
      end
      // asynchronous reset while an interrupt is pending
      #2 rst = 1'b1;
      #1;
      outs = {int_req, clr_pulse, width_vld, stuck_err, last_width, int_cnt, glitch_cnt, last_ts, dbg_state};
      n_checks++;
      if (outs !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", outs); end
      @(negedge clk_32k);
      rst = 1'b0; int_in = 1'b0;
   endtask

   task automatic test_glitch();
      do_reset();
      set_cfg(0, 0, 3, 0);
      int_in = 1'b1;
      repeat (2) @(negedge clk_32k);
      int_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_32k);
         n_checks++;
         if (int_req !== 1'b0) begin n_fail++; $display("FAIL glitch_req c%0d: int_req=%b expected 0", i, int_req); end
      end
      n_checks++;
      if (glitch_cnt !== CW'(1) || int_cnt !== CW'(0)) begin
         n_fail++; $display("FAIL glitch_cnt: glitch=%0d int=%0d expected 1/0", glitch_cnt, int_cnt);
      end
   endtask

   task automatic test_pulse_accept();
      do_reset();
      set_cfg(0, 0, 3, 0);
      int_in = 1'b1;
      for (int i = 1; i <= 640; i++) begin
         @(negedge clk_32k);
         if (i == 4 || i == 5) begin
            n_checks++;
            if (int_req !== (i == 5)) begin n_fail++; $display("FAIL pulse_req_edge%0d: int_req=%b expected %b", i, int_req, i == 5); end
         end
      end
      int_in = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk_32k);
         n_checks++;
         if (width_vld !== (j == 3)) begin n_fail++; $display("FAIL pulse_width_vld j%0d: %b expected %b", j, width_vld, j == 3); end
         if (j == 3) begin
            n_checks++;
            if (last_width !== WW'(640)) begin n_fail++; $display("FAIL pulse_last_width: %0d expected 640", last_width); end
         end
      end
      n_checks++;
      if (int_cnt !== CW'(1) || glitch_cnt !== CW'(0)) begin
         n_fail++; $display("FAIL pulse_counts: int=%0d glitch=%0d expected 1/0", int_cnt, glitch_cnt);
      end
      int_ack = 1'b1;
      @(negedge clk_32k);
      int_ack = 1'b0;
      n_checks++;
      if (clr_pulse !== 1'b1 || int_req !== 1'b0) begin
         n_fail++; $display("FAIL pulse_ack: clr=%b req=%b expected 1/0", clr_pulse, int_req);
      end
      @(negedge clk_32k);
      n_checks++;
      if (clr_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_clr_len: clr=%b expected 0", clr_pulse); end
   endtask

   task automatic test_level_stuck();
      int w;
      do_reset();
      set_cfg(1, 1, 0, 16);
      int_in = 1'b0;
      w = 0;
      while (int_req !== 1'b1 && w < 10) begin @(negedge clk_32k); w++; end
      n_checks++;
      if (int_req !== 1'b1) begin n_fail++; $display("FAIL stuck_wait_req: int_req=%b expected 1 within 10", int_req); end
      int_ack = 1'b1;
      @(negedge clk_32k);
      int_ack = 1'b0;
      n_checks++;
      if (clr_pulse !== 1'b1) begin n_fail++; $display("FAIL stuck_clr: clr=%b expected 1", clr_pulse); end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_32k);
         n_checks++;
         if (stuck_err !== (k >= 16)) begin n_fail++; $display("FAIL stuck_err k%0d: %b expected %b", k, stuck_err, k >= 16); end
      end
      int_in = 1'b1; err_clr = 1'b1;
      @(negedge clk_32k);
      err_clr = 1'b0;
      n_checks++;
      if (stuck_err !== 1'b0) begin n_fail++; $display("FAIL stuck_err_clr: %b expected 0", stuck_err); end
   endtask

   task automatic test_collision();
      int w;
      do_reset();
      set_cfg(0, 0, 2, 0);
      int_in = 1'b1;
      w = 0;
      while (int_req !== 1'b1 && w < 10) begin @(negedge clk_32k); w++; end
      int_in = 1'b0; int_ack = 1'b1;
      @(negedge clk_32k);
      int_ack = 1'b0;
      repeat (6) @(negedge clk_32k);
      n_checks++;
      if (int_req !== 1'b0 || int_cnt !== CW'(1)) begin
         n_fail++; $display("FAIL coll_first: req=%b cnt=%0d expected 0/1", int_req, int_cnt);
      end
      int_in = 1'b1;
      repeat (3) @(negedge clk_32k);
      int_ack = 1'b1;
      @(negedge clk_32k);
      int_ack = 1'b0;
      n_checks++;
      if (clr_pulse !== 1'b1 || int_req !== 1'b1 || int_cnt !== CW'(2)) begin
         n_fail++; $display("FAIL coll_edge: clr=%b req=%b cnt=%0d expected 1/1/2", clr_pulse, int_req, int_cnt);
      end
      @(negedge clk_32k);
      n_checks++;
      if (clr_pulse !== 1'b0 || int_req !== 1'b1) begin
         n_fail++; $display("FAIL coll_after: clr=%b req=%b expected 0/1", clr_pulse, int_req);
      end
      int_in = 1'b0;
   endtask

   task automatic test_timestamp();
      logic [TW-1:0] exp_ts;
`ifdef INT_RX_TIMESTAMP_EN
      exp_ts = TW'(100);
`else
      exp_ts = '0;
`endif
      do_reset();
      set_cfg(0, 0, 0, 0);
      repeat (98) @(negedge clk_32k);
      int_in = 1'b1;
      repeat (3) @(negedge clk_32k);
      n_checks++;
      if (int_req !== 1'b1 || last_ts !== exp_ts) begin
         n_fail++; $display("FAIL timestamp: req=%b last_ts=%0d expected 1/%0d", int_req, last_ts, exp_ts);
      end
      int_in = 1'b0;
   endtask

   task automatic test_random();
      logic [46:0] got, exp;
      logic [WW-1:0] wexp;
      int hold;
      do_reset();
      set_cfg(0, 0, 2, 6);
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_32k);
         got = {int_req, clr_pulse, width_vld, stuck_err, last_width, int_cnt, glitch_cnt, last_ts};
         exp = {m_req, m_clr, m_wv, m_stk, WW'(m_lw), CW'(m_ic), CW'(m_gc), TW'(m_lts)};
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL random_outputs c%0d: got %h expected %h", c, got, exp); end
         if (width_vld === 1'b1) begin
            wexp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if (last_width !== wexp) begin n_fail++; $display("FAIL random_width c%0d: got %0d expected %0d", c, last_width, wexp); end
         end
         if (hold == 0) begin
            int_in = ~int_in;
            hold = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 299) == 0) rg_int_low_en   = ~rg_int_low_en;
         if ($urandom_range(0, 149) == 0) rg_int_level_en = ~rg_int_level_en;
         if ($urandom_range(0, 99)  == 0) rg_min_width    = WW'($urandom_range(0, 5));
         if ($urandom_range(0, 99)  == 0) rg_clr_to       = 8'($urandom_range(0, 10));
         int_ack = ($urandom_range(0, 7) == 0);
         err_clr = ($urandom_range(0, 23) == 0);
      end
      int_ack = 1'b0; err_clr = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_scoreboard: %0d widths not observed, expected 0", exp_q.size()); end
   endtask

   // ------------------------------------------------------------ main
   initial begin
      test_reset();
      test_glitch();
      test_pulse_accept();
      test_level_stuck();
      test_collision();
      test_timestamp();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
